// File: rtl/reg_display.sv
// Register debug display: selects a CPU register (manual or auto-stepped), snapshots it
// once per frame and scans it as eight hex digits onto a common-anode 7-segment display.
module reg_display #(
    parameter int CLK_DIV     = 100000,
    parameter int AUTO_PERIOD = 100000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  sw_sel,
    input  logic        auto_en,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_sel,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    dig_q, dig_d;
    logic [AW-1:0] auto_q, auto_d;
    logic [4:0]    sel_q, sel_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          tick;
    logic [3:0]    nibble;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        tick     = (div_q == DIV_LAST);
        div_d    = tick ? '0 : div_q + DW'(1);
        dig_d    = tick ? dig_q + 3'd1 : dig_q;
        // Capture only at the frame boundary so all eight digits show one coherent value.
        shadow_d = (tick && dig_q == 3'd7) ? reg_data : shadow_q;

        if (!auto_en) begin
            sel_d  = sw_sel;
            auto_d = '0;
        end else if (auto_q == AUTO_LAST) begin
            sel_d  = sel_q + 5'd1;
            auto_d = '0;
        end else begin
            sel_d  = sel_q;
            auto_d = auto_q + AW'(1);
        end

        nibble = shadow_q[{dig_q, 2'b00} +: 4];
        an_d   = ~(8'd1 << dig_q);
        seg_d  = {~(dig_q == 3'd7 && auto_en), hex7(nibble)};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_q    <= '0;
            dig_q    <= '0;
            auto_q   <= '0;
            sel_q    <= '0;
            shadow_q <= '0;
            an_q     <= 8'hFF;
            seg_q    <= 8'hFF;
        end else begin
            div_q    <= div_d;
            dig_q    <= dig_d;
            auto_q   <= auto_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign reg_sel = sel_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule

// File: tb/tb_reg_display.sv
// Scoreboarded bench for reg_display: a cycle-count reference model queues the expected
// outputs each edge; a negedge monitor pops and compares them with the DUT.
module tb_reg_display;

    localparam int CLK_DIV     = 4;
    localparam int AUTO_PERIOD = 10;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic [4:0] sel;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [4:0]  sw_sel;
    logic        auto_en;
    logic [31:0] reg_data;
    logic [4:0]  reg_sel;
    logic [7:0]  an;
    logic [7:0]  seg;

    logic [31:0] regs [32];
    logic [6:0]  hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    reg_display #(.CLK_DIV(CLK_DIV), .AUTO_PERIOD(AUTO_PERIOD)) dut (
        .clk(clk), .rstn(rstn), .sw_sel(sw_sel), .auto_en(auto_en),
        .reg_data(reg_data), .reg_sel(reg_sel), .an(an), .seg(seg)
    );

    assign reg_data = regs[reg_sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: everything derived from the number of edges since reset release.
    int          n = 0;
    int          ak = 0;
    logic [31:0] m_sh = '0;
    logic [4:0]  m_sel = '0;

    always @(posedge clk) begin
        exp_t e;
        int   d;
        logic [3:0] nib;
        if (!rstn) begin
            n = 0; ak = 0; m_sh = '0; m_sel = '0;
            e.an = 8'hFF; e.seg = 8'hFF;
        end else begin
            d = (n / CLK_DIV) % 8;
            e.an = ~(8'h01 << d);
            nib = 4'((m_sh >> (4 * d)) & 32'hF);
            e.seg = {!(d == 7 && auto_en), hex_tbl[nib]};
            if (n % (8 * CLK_DIV) == 8 * CLK_DIV - 1) m_sh = regs[m_sel];
            if (auto_en) begin
                if ((ak + 1) % AUTO_PERIOD == 0) m_sel = m_sel + 5'd1;
                ak++;
            end else begin
                m_sel = sw_sel;
                ak = 0;
            end
            n++;
        end
        e.sel = m_sel;
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (an !== e.an) begin
                bad++; $display("FAIL an: got %h want %h at %0t", an, e.an, $time);
            end
            total++;
            if (seg !== e.seg) begin
                bad++; $display("FAIL seg: got %h want %h at %0t", seg, e.seg, $time);
            end
            total++;
            if (reg_sel !== e.sel) begin
                bad++; $display("FAIL reg_sel: got %0d want %0d at %0t", reg_sel, e.sel, $time);
            end
            if (e.an != 8'hFF) begin
                total++;
                if ($countones(~an) != 1) begin
                    bad++; $display("FAIL onehot_an: got %h want exactly one low bit", an);
                end
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_an(input logic [7:0] v);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (an === v) break;
        end
        total++;
        if (i == 200) begin
            bad++; $display("FAIL wait_an: got %h want %h within 200 cycles", an, v);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[5]  = 32'h89AB_CDEF;
        rstn     = 1'b0;
        sw_sel   = 5'd0;
        auto_en  = 1'b0;
        cycles(3);
        rstn = 1'b1;
        cycles(40);

        sw_sel = 5'd5;
        cycles(80);

        // Rewrite the selected register while digit 3 is being shown.
        wait_an(8'hF7);
        regs[5] = 32'h1234_5678;
        cycles(70);

        sw_sel = 5'd30;
        cycles(2);
        auto_en = 1'b1;
        cycles(35);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 9) == 0)  sw_sel = 5'($urandom);
            if ($urandom_range(0, 19) == 0) regs[$urandom_range(0, 31)] = $urandom;
            cycles(1);
        end

        auto_en = 1'b0;
        sw_sel  = 5'd17;
        cycles(2);
        wait_an(8'hDF);
        rstn = 1'b0;
        cycles(1);
        rstn = 1'b1;
        cycles(40);

        cycles(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
